// File: rtl/datapath_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// datapath_sequencer_pkg
// Shared definitions for the datapath sequencer: FSM state encoding, opcode
// constants, datapath flag bit positions and the dp_code field layout.
// No ports (package).
// -----------------------------------------------------------------------------
package datapath_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_CAPTURE,
        ST_FINISH
    } seq_state_t;

    // Opcodes handled by the sequencer itself; every other opcode is an ALU op
    localparam logic [3:0] OP_BRANCH = 4'hC;
    localparam logic [3:0] OP_HALT   = 4'hF;

    // Bit positions inside dp_flags
    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_Z = 1;

    // dp_code / instruction word field positions
    localparam int unsigned CODE_OP_MSB  = 15;
    localparam int unsigned CODE_OP_LSB  = 12;
    localparam int unsigned CODE_A_MSB   = 11;
    localparam int unsigned CODE_A_LSB   = 8;
    localparam int unsigned CODE_EXT_MSB = 7;
    localparam int unsigned CODE_EXT_LSB = 4;
    localparam int unsigned CODE_B_MSB   = 3;
    localparam int unsigned CODE_B_LSB   = 0;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op != OP_BRANCH) && (op != OP_HALT);
    endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// -----------------------------------------------------------------------------
// datapath_sequencer_if
// Bundles the sequencer's control, instruction-fetch and datapath signals.
//   master : sequencer side (drives instr_addr, dp_code, dp_en, dp_cin,
//            busy, done, timeout; receives start, instr_data, instr_valid,
//            dp_flags)
//   slave  : environment side (instruction memory, datapath, controller)
// -----------------------------------------------------------------------------
interface datapath_sequencer_if #(
    parameter int unsigned IMEM_AW = 8
);
    logic               start;
    logic [IMEM_AW-1:0] instr_addr;
    logic [15:0]        instr_data;
    logic               instr_valid;
    logic [15:0]        dp_code;
    logic [15:0]        dp_en;
    logic               dp_cin;
    logic [4:0]         dp_flags;
    logic               busy;
    logic               done;
    logic               timeout;

    modport master (
        input  start, instr_data, instr_valid, dp_flags,
        output instr_addr, dp_code, dp_en, dp_cin, busy, done, timeout
    );

    modport slave (
        output start, instr_data, instr_valid, dp_flags,
        input  instr_addr, dp_code, dp_en, dp_cin, busy, done, timeout
    );
endinterface

// File: rtl/datapath_sequencer_onehot_decoder16.sv
// -----------------------------------------------------------------------------
// onehot_decoder16
// Maps a 4-bit register index to a 16-bit one-hot write enable.
//   sel    in  4   register index
//   onehot out 16  one-hot value, bit sel set
// -----------------------------------------------------------------------------
module onehot_decoder16 (
    input  logic [3:0]  sel,
    output logic [15:0] onehot
);
    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end
endmodule

// File: rtl/datapath_sequencer.sv
// -----------------------------------------------------------------------------
// datapath_sequencer
// Fetches 16-bit instructions from PC = 0 upward and drives a register-file
// datapath: ALU ops issue one dp_en pulse and capture C/Z flags, BRANCH jumps
// PC-relative when Z is set, HALT ends the run. A watchdog ends a run after
// MAX_STEPS executed instructions and flags it with a sticky timeout.
//
// Parameters: IMEM_AW (instruction address width), MAX_STEPS (watchdog limit)
// Ports:
//   clk    in   clock, posedge
//   reset  in   synchronous, active-high
//   bus    datapath_sequencer_if.master:
//          start, instr_addr, instr_data, instr_valid, dp_code, dp_en,
//          dp_cin, dp_flags, busy, done, timeout
// Build option: define SEQ_CARRY_CHAIN_EN to store the C flag and feed it to
// dp_cin during ALU execution; otherwise dp_cin is tied low.
// -----------------------------------------------------------------------------
module datapath_sequencer
    import datapath_sequencer_pkg::*;
#(
    parameter int unsigned IMEM_AW   = 8,
    parameter int unsigned MAX_STEPS = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    datapath_sequencer_if.master bus
);

    localparam int unsigned       STEP_W     = $clog2(MAX_STEPS + 1);
    localparam int unsigned       OFF_W      = (IMEM_AW > 8) ? IMEM_AW : 8;
    localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

    seq_state_t         state_q;
    seq_state_t         state_d;
    logic [IMEM_AW-1:0] pc_q;
    logic [15:0]        ir_q;
    logic [STEP_W-1:0]  step_q;
    logic               flag_z_q;
    logic               timeout_q;

    logic [3:0]         ir_op;
    logic               exec_alu;
    logic               exec_branch;
    logic               exec_halt;
    logic [STEP_W-1:0]  step_inc;
    logic               step_limit;
    logic               timeout_set;
    logic [OFF_W-1:0]   br_off;
    logic [IMEM_AW-1:0] pc_inc;
    logic [IMEM_AW-1:0] pc_branch;
    logic [15:0]        dest_onehot;
    logic               carry_in;
    logic               run_start;
    logic               unused_flags;

    // ------------------------------------------------------------------
    // Decode and arithmetic helpers
    // ------------------------------------------------------------------
    always_comb begin
        ir_op       = ir_q[CODE_OP_MSB:CODE_OP_LSB];
        exec_alu    = (state_q == ST_EXEC) && is_alu_op(ir_op);
        exec_branch = (state_q == ST_EXEC) && (ir_op == OP_BRANCH);
        exec_halt   = (state_q == ST_EXEC) && (ir_op == OP_HALT);
        run_start   = (state_q == ST_IDLE) && bus.start;

        step_inc    = step_q + STEP_W'(1);
        step_limit  = (step_inc == STEP_LIMIT);
        // Only instructions that bump the step counter can trip the watchdog
        timeout_set = step_limit && (exec_branch || (state_q == ST_CAPTURE));

        // Branch offset is IR[7:0] sign-extended; truncating to IMEM_AW
        // makes both forward and backward jumps wrap modulo 2^IMEM_AW.
        br_off      = OFF_W'($signed(ir_q[CODE_EXT_MSB:CODE_B_LSB]));
        pc_inc      = pc_q + IMEM_AW'(1);
        pc_branch   = pc_q + br_off[IMEM_AW-1:0];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.instr_valid) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (exec_halt)        state_d = ST_FINISH;
                else if (exec_branch) state_d = step_limit ? ST_FINISH : ST_FETCH;
                else                  state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d = step_limit ? ST_FINISH : ST_FETCH;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // PC, IR, step counter, Z flag, timeout
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= '0;
            ir_q      <= '0;
            step_q    <= '0;
            flag_z_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (run_start) begin
                pc_q      <= '0;
                step_q    <= '0;
                flag_z_q  <= 1'b0;
                timeout_q <= 1'b0;
            end
            if ((state_q == ST_FETCH) && bus.instr_valid) begin
                ir_q <= bus.instr_data;
            end
            if (exec_branch) begin
                pc_q   <= flag_z_q ? pc_branch : pc_inc;
                step_q <= step_inc;
            end
            if (state_q == ST_CAPTURE) begin
                flag_z_q <= bus.dp_flags[FLAG_Z];
                pc_q     <= pc_inc;
                step_q   <= step_inc;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef SEQ_CARRY_CHAIN_EN
    logic flag_c_q;

    always_ff @(posedge clk) begin
        if (reset)                     flag_c_q <= 1'b0;
        else if (run_start)            flag_c_q <= 1'b0;
        else if (state_q == ST_CAPTURE) flag_c_q <= bus.dp_flags[FLAG_C];
    end

    assign carry_in     = flag_c_q;
    assign unused_flags = ^{bus.dp_flags[4], bus.dp_flags[2], bus.dp_flags[0]};
`else
    assign carry_in     = 1'b0;
    assign unused_flags = ^{bus.dp_flags[4], bus.dp_flags[3],
                            bus.dp_flags[2], bus.dp_flags[0]};
`endif

    onehot_decoder16 u_dest_dec (
        .sel    (ir_q[CODE_B_MSB:CODE_B_LSB]),
        .onehot (dest_onehot)
    );

    // ------------------------------------------------------------------
    // Outputs. Datapath-facing and status outputs are masked by reset so
    // nothing fires in the cycle reset is applied, even mid-EXEC.
    // ------------------------------------------------------------------
    assign bus.instr_addr = pc_q;
    assign bus.dp_code    = (exec_alu && !reset) ? ir_q : '0;
    assign bus.dp_en      = (exec_alu && !reset) ? dest_onehot : '0;
    assign bus.dp_cin     = exec_alu && !reset && carry_in;
    assign bus.busy       = (state_q != ST_IDLE) && !reset;
    assign bus.done       = (state_q == ST_FINISH) && !reset;
    assign bus.timeout    = timeout_q && !reset;

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 Parameter IMEM_AW, default 8: instruction address width in bits.
REQ-002 Parameter MAX_STEPS, default 1024: watchdog limit on executed instructions per run.
REQ-003 clk  input  1  clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 start  input  1  begin a program run at address 0; honoured only in IDLE.
REQ-006 instr_addr  output  IMEM_AW  instruction fetch address (the PC).
REQ-007 instr_data  input  16  fetched instruction word.
REQ-008 instr_valid  input  1  instr_data is valid for instr_addr this cycle.
REQ-009 dp_code  output  16  opcode/register word to the datapath: [15:12] op, [11:8] A reg, [7:4] ext op, [3:0] B/dest reg.
REQ-010 dp_en  output  16  one-hot register write enable to the datapath.
REQ-011 dp_cin  output  1  carry-in to the datapath.
REQ-012 dp_flags  input  5  datapath flags, registered by the datapath; bit 3 = C, bit 1 = Z.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when a run ends.
REQ-015 timeout  output  1  sticky; set when a run ends by watchdog; cleared on start or reset.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, EXEC, CAPTURE, FINISH.
REQ-017 IDLE -> FETCH on start; on that transition PC and step counter clear and the latched C/Z flags clear.
REQ-018 FETCH SHALL drive instr_addr = PC and hold until instr_valid; then it latches instr_data into IR and goes to EXEC. Fetch stalls indefinitely without instr_valid.
REQ-019 EXEC, ALU op (IR[15:12] not 4'hC and not 4'hF): exactly one cycle with dp_code = IR and dp_en = one-hot(IR[3:0]); then CAPTURE.
REQ-020 In every state except EXEC-with-ALU-op, dp_en SHALL be 16'h0000 and dp_code SHALL be 16'h0000.
REQ-021 CAPTURE SHALL latch dp_flags[3] and dp_flags[1] into C and Z, increment PC, increment the step counter, and go to FETCH.
REQ-022 EXEC, BRANCH (IR[15:12] = 4'hC): no datapath write. If Z = 1, PC <= PC + sign-extended IR[7:0]; otherwise PC <= PC + 1. Step counter increments. Next state is FETCH.
REQ-023 EXEC, HALT (IR[15:12] = 4'hF): go to FINISH with no datapath write.
REQ-024 PC arithmetic SHALL be modulo 2^IMEM_AW: 2^IMEM_AW-1 + 1 wraps to 0, and negative branch offsets wrap likewise.
REQ-025 When the step counter reaches MAX_STEPS on its increment, the next state SHALL be FINISH instead of FETCH, with timeout set.
REQ-026 FINISH SHALL assert done for one cycle and then return to IDLE.
REQ-027 start asserted while busy SHALL be ignored.
REQ-028 An ALU op takes 3 cycles minimum (FETCH, EXEC, CAPTURE); a branch takes 2 cycles minimum.

Reset
REQ-029 Reset SHALL take priority over all inputs and force IDLE with PC = 0, IR = 0, step counter 0, C = Z = 0, dp_en = 0, dp_code = 0, dp_cin = 0, busy = 0, done = 0, timeout = 0.
REQ-030 Reset mid-run SHALL abort the run with no done pulse; no dp_en pulse occurs in the reset cycle or in the following cycle.

Configuration
REQ-031 With macro SEQ_CARRY_CHAIN_EN defined, dp_cin SHALL equal latched C during EXEC of an ALU op and 0 otherwise.
REQ-032 With SEQ_CARRY_CHAIN_EN undefined, dp_cin SHALL be constant 0 and no C flag storage is built.

Structure
REQ-033 The shared package SHALL hold the state enum, the opcode constants OP_BRANCH = 4'hC and OP_HALT = 4'hF, the flag bit indices FLAG_C = 3 and FLAG_Z = 1, and the dp_code field positions.
REQ-034 There SHALL be one sub-module, onehot_decoder16, which maps 4 bits to a 16-bit one-hot value; everything else is flat.

Verification
REQ-035 Reset, then start; memory returns 16'h0051 at address 0 and 16'hF000 at address 1, with instr_valid always high -> dp_en = 16'h0002 for exactly one cycle, then done pulses; total 6 cycles from start to done.
REQ-036 Memory at address 0 is 16'hC0FE with Z latched 1 -> next fetch is at address 0xFE; with Z = 0 -> next fetch is at address 0x01.
REQ-037 Program of 15 chained adds (A = r(n-1), dest = r(n)) followed by HALT -> dp_en walks 16'h0002 through 16'h8000 in order, then done.
REQ-038 Memory at address 0 is a branch to itself (16'hC000) with Z = 1 and MAX_STEPS = 4 -> exactly 4 fetches, then done = 1 and timeout = 1.
REQ-039 instr_valid held low for 5 cycles in FETCH -> no dp_en pulse and instr_addr stable; then a reset pulse mid-EXEC -> IDLE next cycle, busy = 0, no done pulse.
REQ-040 With SEQ_CARRY_CHAIN_EN defined and dp_flags[3] = 1 at CAPTURE -> dp_cin = 1 in the next ALU EXEC; with the macro undefined -> dp_cin = 0 throughout.
